// File: rtl/mac_operand_fetch_pkg.sv
// Shared types and defaults for the MAC operand fetch unit.
// FIFO entries are packed as {last, b, a} with a in the low DATA_W bits.
package mac_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic int entry_w(input int data_w);
    return 2 * data_w + 1;
  endfunction

endpackage

// File: rtl/mac_operand_fetch_if.sv
// Memory read ports and operand handshake between the fetch unit (master) and its memories/MAC (slave).
// Handshake: a pair transfers on a clock edge where op_valid & op_ready; while op_valid & !op_ready
// the master holds op_a/op_b/op_last stable. Memory rdata is valid the cycle after its rd strobe.
interface mac_operand_fetch_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              mem_a_rd;
  logic [ADDR_W-1:0] mem_a_addr;
  logic [DATA_W-1:0] mem_a_rdata;
  logic              mem_b_rd;
  logic [ADDR_W-1:0] mem_b_addr;
  logic [DATA_W-1:0] mem_b_rdata;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_last;

  modport master (
    output mem_a_rd, mem_a_addr, input mem_a_rdata,
    output mem_b_rd, mem_b_addr, input mem_b_rdata,
    output op_valid, op_a, op_b, op_last,
    input  op_ready
  );

  modport slave (
    input  mem_a_rd, mem_a_addr, output mem_a_rdata,
    input  mem_b_rd, mem_b_addr, output mem_b_rdata,
    input  op_valid, op_a, op_b, op_last,
    output op_ready
  );
endinterface

// File: rtl/mac_operand_fetch_opfifo.sv
// Synchronous operand FIFO with occupancy count; no bypass, so data written is visible next cycle.
module mac_opfifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mac_operand_fetch.sv
// Streams LEN element pairs from memories A/B into an operand FIFO for the MAC stage.
// Optional MAC_FETCH_PERF_EN adds a saturating stall_cnt output.
module mac_operand_fetch
  import mac_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  mac_operand_fetch_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_t            state_dbg
`ifdef MAC_FETCH_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = entry_w(DATA_W);
  localparam logic [ADDR_W:0] ONE     = 1;
  localparam logic [CNT_W:0]  DEPTH_V = DEPTH;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W-1:0] base_a_q;
  logic [ADDR_W-1:0] base_b_q;
  logic              inflight;
  logic              inflight_last;
  logic              start_ok;
  logic              rd;
  logic              last_rd;
  logic              pop;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;

  assign start_ok = (state == S_IDLE) && start && (len != '0);
  // Reserve a slot for the read whose data is still on the memory bus.
  assign rd = (state == S_FETCH) && !fifo_full &&
              (({1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight}) < DEPTH_V);
  assign last_rd = rd && ((idx + ONE) == len_q);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_ok) state_nx = S_FETCH;
      S_FETCH: if (last_rd) state_nx = S_DRAIN;
      S_DRAIN: if (!inflight && fifo_empty) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      len_q         <= '0;
      idx           <= '0;
      base_a_q      <= '0;
      base_b_q      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_nx;
      inflight      <= rd;
      inflight_last <= last_rd;
      err           <= (state == S_IDLE) && start && (len == '0);
      if (start_ok) begin
        len_q    <= len;
        base_a_q <= base_a;
        base_b_q <= base_b;
        idx      <= '0;
      end else if (rd) begin
        idx <= idx + ONE;
      end
    end
  end

  assign busy      = (state == S_FETCH) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  // Addresses wrap naturally in ADDR_W bits; they read as zero when no strobe is issued.
  assign bus.mem_a_rd   = rd;
  assign bus.mem_b_rd   = rd;
  assign bus.mem_a_addr = rd ? (base_a_q + idx[ADDR_W-1:0]) : '0;
  assign bus.mem_b_addr = rd ? (base_b_q + idx[ADDR_W-1:0]) : '0;

  assign wr_entry = {inflight_last, bus.mem_b_rdata, bus.mem_a_rdata};
  assign pop      = !fifo_empty && bus.op_ready;

  mac_opfifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.op_valid = !fifo_empty;
  assign bus.op_a     = bus.op_valid ? head[DATA_W-1:0] : '0;
  assign bus.op_b     = bus.op_valid ? head[2*DATA_W-1:DATA_W] : '0;
  assign bus.op_last  = bus.op_valid ? head[ENTRY_W-1] : 1'b0;

`ifdef MAC_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if (bus.op_valid && !bus.op_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mac_operand_fetch.sv
// Self-checking bench for mac_operand_fetch: memory models, pair-order reference queue, scenario tasks.
module tb_mac_operand_fetch;
  import mac_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;
  localparam int NMEM   = 16;
  localparam int EW     = 2 * DATA_W + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   len = '0;
  logic [ADDR_W-1:0] base_a = '0;
  logic [ADDR_W-1:0] base_b = '0;
  logic              busy;
  logic              done;
  logic              err;
  state_t            state_dbg;
`ifdef MAC_FETCH_PERF_EN
  logic [15:0]       stall_cnt;
`endif

  mac_operand_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mac_operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .base_a    (base_a),
    .base_b    (base_b),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg)
`ifdef MAC_FETCH_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  logic [DATA_W-1:0] mem_a [NMEM];
  logic [DATA_W-1:0] mem_b [NMEM];
  logic [EW-1:0]     exp_q[$];
  int errors = 0;
  int checks = 0;

  // ---------------- clock / memories ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_a_rd) bus.mem_a_rdata <= mem_a[bus.mem_a_addr];
    if (bus.mem_b_rd) bus.mem_b_rdata <= mem_b[bus.mem_b_addr];
  end

  // ---------------- driver tasks / model ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NMEM; i++) begin
      mem_a[i] = DATA_W'($urandom_range(0, 255));
      mem_b[i] = DATA_W'($urandom_range(0, 255));
    end
  endtask

  // Reference: pair i is A[(base_a+i) mod 16], B[(base_b+i) mod 16], last on i==n-1.
  task automatic model_load(input int n, input int ba, input int bb);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(i == n - 1), mem_b[(bb + i) % NMEM], mem_a[(ba + i) % NMEM]});
    end
  endtask

  // Leaves the bench 1 ns after the edge that samples start ("cycle 0").
  task automatic start_run(input int n, input int ba, input int bb);
    len    = (ADDR_W+1)'(n);
    base_a = ADDR_W'(ba);
    base_b = ADDR_W'(bb);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [30:0] outs;
    bus.op_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) tick();
    outs = {bus.op_valid, bus.op_last, bus.op_a, bus.op_b, busy, done, err,
            bus.mem_a_rd, bus.mem_b_rd, bus.mem_a_addr, bus.mem_b_addr};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (state_dbg !== S_IDLE || busy !== 1'b0 || bus.op_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle state=%0d busy=%b valid=%b exp idle/0/0", state_dbg, busy, bus.op_valid);
    end
  endtask

  task automatic test_latency();
    logic [EW-1:0] got;
    logic [EW-1:0] want;
    fill_random();
    model_load(1, 3, 9);
    want = exp_q.pop_front();
    bus.op_ready = 1'b1;
    start_run(1, 3, 9);
    checks++;
    if (bus.mem_a_rd !== 1'b1 || bus.mem_a_addr !== 4'd3 || bus.mem_b_addr !== 4'd9 || busy !== 1'b1) begin
      errors++;
      $display("FAIL lat_read rd=%b a=%0d b=%0d busy=%b exp 1/3/9/1", bus.mem_a_rd, bus.mem_a_addr, bus.mem_b_addr, busy);
    end
    tick();
    checks++;
    if (bus.op_valid !== 1'b0 || bus.mem_a_rd !== 1'b0) begin
      errors++;
      $display("FAIL lat_cycle1 valid=%b rd=%b exp 0/0", bus.op_valid, bus.mem_a_rd);
    end
    tick();
    got = {bus.op_last, bus.op_b, bus.op_a};
    checks++;
    if (bus.op_valid !== 1'b1 || got !== want) begin
      errors++;
      $display("FAIL lat_cycle2 valid=%b pair=%h exp 1/%h", bus.op_valid, got, want);
    end
    tick();
    checks++;
    if (bus.op_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL lat_cycle3 valid=%b done=%b busy=%b exp 0/0/1", bus.op_valid, done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL lat_done done=%b busy=%b exp 1/0", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL lat_done_pulse done=%b state=%0d exp 0/idle", done, state_dbg);
    end
  endtask

  task automatic test_basic();
    logic [EW-1:0] got;
    logic [EW-1:0] want;
    int cyc = 0;
    int done_n = 0;
    for (int i = 0; i < NMEM; i++) begin
      mem_a[i] = DATA_W'(i + 1);
      mem_b[i] = DATA_W'(2);
    end
    model_load(4, 0, 8);
    bus.op_ready = 1'b1;
    start_run(4, 0, 8);
    while ((exp_q.size() != 0 || busy) && cyc < 60) begin
      if (done) done_n++;
      if (bus.op_valid && bus.op_ready) begin
        got = {bus.op_last, bus.op_b, bus.op_a};
        want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL basic_pair got=%h exp=%h", got, want);
        end
      end
      tick();
      cyc++;
    end
    repeat (3) begin
      if (done) done_n++;
      tick();
    end
    checks++;
    if (cyc >= 60 || exp_q.size() != 0 || done_n != 1) begin
      errors++;
      $display("FAIL basic_end cycles=%0d left=%0d done_pulses=%0d exp <60/0/1", cyc, exp_q.size(), done_n);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] got;
    logic [EW-1:0] want;
    int reads = 0;
    int strobe_skew = 0;
    int stall_exp = 0;
    int cyc = 0;
    int ba;
    int bb;
    fill_random();
    ba = $urandom_range(0, NMEM - 1);
    bb = $urandom_range(0, NMEM - 1);
    model_load(8, ba, bb);
    bus.op_ready = 1'b0;
    start_run(8, ba, bb);
    repeat (12) begin
      if (bus.mem_a_rd) reads++;
      if (bus.mem_a_rd !== bus.mem_b_rd) strobe_skew++;
      if (bus.op_valid) stall_exp++;
      tick();
    end
    checks++;
    if (reads != DEPTH || strobe_skew != 0) begin
      errors++;
      $display("FAIL bp_outstanding reads=%0d skew=%0d exp %0d/0", reads, strobe_skew, DEPTH);
    end
    checks++;
    if (state_dbg !== S_FETCH || bus.op_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_stalled state=%0d valid=%b exp fetch/1", state_dbg, bus.op_valid);
    end
    bus.op_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && cyc < 80) begin
      if (bus.op_valid && bus.op_ready) begin
        got = {bus.op_last, bus.op_b, bus.op_a};
        want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL bp_pair got=%h exp=%h", got, want);
        end
      end
      tick();
      cyc++;
    end
    repeat (3) tick();
    checks++;
    if (cyc >= 80 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_end cycles=%0d left=%0d exp <80/0", cyc, exp_q.size());
    end
`ifdef MAC_FETCH_PERF_EN
    checks++;
    if (stall_cnt !== 16'(stall_exp)) begin
      errors++;
      $display("FAIL bp_stall_cnt got=%0d exp=%0d", stall_cnt, stall_exp);
    end
`endif
    exp_q.delete();
  endtask

  task automatic test_error();
    int bad = 0;
    start_run(0, 5, 6);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || bus.mem_a_rd !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse err=%b busy=%b rd=%b exp 1/0/0", err, busy, bus.mem_a_rd);
    end
    tick();
    repeat (4) begin
      if (err || busy || bus.mem_a_rd || bus.mem_b_rd || bus.op_valid) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL err_after bad_cycles=%0d state=%0d exp 0/idle", bad, state_dbg);
    end
  endtask

  task automatic test_wrap();
    logic [EW-1:0]     got;
    logic [EW-1:0]     want;
    logic [ADDR_W-1:0] addr_q[$];
    logic [ADDR_W-1:0] exp_addr;
    int n;
    int ba;
    int bb;
    int cyc;
    int lasts;
    for (int run = 0; run < 2; run++) begin
      fill_random();
      n  = (run == 0) ? 4 : 16;
      ba = (run == 0) ? 14 : $urandom_range(0, NMEM - 1);
      bb = $urandom_range(0, NMEM - 1);
      addr_q.delete();
      model_load(n, ba, bb);
      bus.op_ready = 1'b1;
      cyc = 0;
      lasts = 0;
      start_run(n, ba, bb);
      while ((exp_q.size() != 0 || busy) && cyc < 80) begin
        if (bus.mem_a_rd) addr_q.push_back(bus.mem_a_addr);
        if (bus.op_valid && bus.op_ready) begin
          if (bus.op_last) lasts++;
          got = {bus.op_last, bus.op_b, bus.op_a};
          want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
          checks++;
          if (got !== want) begin
            errors++;
            $display("FAIL wrap_pair run=%0d got=%h exp=%h", run, got, want);
          end
        end
        tick();
        cyc++;
      end
      repeat (3) tick();
      checks++;
      if (cyc >= 80 || exp_q.size() != 0 || lasts != 1 || addr_q.size() != n) begin
        errors++;
        $display("FAIL wrap_end run=%0d cycles=%0d left=%0d lasts=%0d reads=%0d exp <80/0/1/%0d",
                 run, cyc, exp_q.size(), lasts, addr_q.size(), n);
      end
      for (int i = 0; i < addr_q.size(); i++) begin
        exp_addr = ADDR_W'((ba + i) % NMEM);
        checks++;
        if (addr_q[i] !== exp_addr) begin
          errors++;
          $display("FAIL wrap_addr run=%0d i=%0d got=%0d exp=%0d", run, i, addr_q[i], exp_addr);
        end
      end
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    logic [30:0]   outs;
    logic [EW-1:0] got;
    logic [EW-1:0] want;
    int cyc = 0;
    fill_random();
    bus.op_ready = 1'b0;
    start_run(2, 4, 12);
    repeat (3) tick();
    checks++;
    if (state_dbg !== S_DRAIN || bus.op_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_setup state=%0d valid=%b exp drain/1", state_dbg, bus.op_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    outs = {bus.op_valid, bus.op_last, bus.op_a, bus.op_b, busy, done, err,
            bus.mem_a_rd, bus.mem_b_rd, bus.mem_a_addr, bus.mem_b_addr};
    checks++;
    if (outs !== '0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL rstmid_outputs got=%h state=%0d exp 0/idle", outs, state_dbg);
    end
    tick();
    rst_n = 1'b1;
    tick();
    model_load(3, 1, 2);
    bus.op_ready = 1'b1;
    start_run(3, 1, 2);
    while ((exp_q.size() != 0 || busy) && cyc < 60) begin
      if (bus.op_valid && bus.op_ready) begin
        got = {bus.op_last, bus.op_b, bus.op_a};
        want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL rstmid_pair got=%h exp=%h", got, want);
        end
      end
      tick();
      cyc++;
    end
    repeat (3) tick();
    checks++;
    if (cyc >= 60 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_end cycles=%0d left=%0d exp <60/0", cyc, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_toggle();
    logic [EW-1:0] got;
    logic [EW-1:0] want;
    logic [EW-1:0] hold_val = '0;
    logic          hold_pending = 1'b0;
    int cyc = 0;
    int err_seen = 0;
    int ba;
    int bb;
    fill_random();
    ba = $urandom_range(0, NMEM - 1);
    bb = $urandom_range(0, NMEM - 1);
    model_load(8, ba, bb);
    bus.op_ready = 1'b1;
    start_run(8, ba, bb);
    while ((exp_q.size() != 0 || busy) && cyc < 100) begin
      bus.op_ready = (cyc % 2 == 0);
      start = (cyc == 3 || cyc == 6);
      len   = (cyc == 3) ? '0 : (ADDR_W+1)'(5);
      if (err) err_seen++;
      got = {bus.op_last, bus.op_b, bus.op_a};
      if (hold_pending) begin
        checks++;
        if (bus.op_valid !== 1'b1 || got !== hold_val) begin
          errors++;
          $display("FAIL toggle_hold valid=%b got=%h exp 1/%h", bus.op_valid, got, hold_val);
        end
      end
      if (bus.op_valid && bus.op_ready) begin
        want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL toggle_pair got=%h exp=%h", got, want);
        end
      end
      hold_pending = bus.op_valid && !bus.op_ready;
      hold_val = got;
      tick();
      cyc++;
    end
    start = 1'b0;
    repeat (3) begin
      if (err) err_seen++;
      tick();
    end
    checks++;
    if (cyc >= 100 || exp_q.size() != 0 || err_seen != 0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL toggle_end cycles=%0d left=%0d err_pulses=%0d state=%0d exp <100/0/0/idle",
               cyc, exp_q.size(), err_seen, state_dbg);
    end
    exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.op_ready    = 1'b0;
    bus.mem_a_rdata = '0;
    bus.mem_b_rdata = '0;
    test_reset();
    test_latency();
    test_basic();
    test_backpressure();
    test_error();
    test_wrap();
    test_reset_mid();
    test_toggle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
